// File: rtl/xmit_fifo_if.sv
// xmit_fifo_if: APB push side and UART transmitter side of the transmit FIFO controller.
interface xmit_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                     busy;
    logic                     write_enable;
    logic [31:0]              pDataWrite;
    logic                     flush;
    logic                     overflow_clr;
    logic [DATA_W-1:0]        data_in;
    logic                     tx_enable;
    logic                     xmitEmpty;
    logic                     xmitFull;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     thresh_irq;

    modport slave (
        input  busy, write_enable, pDataWrite, flush, overflow_clr,
        output data_in, tx_enable, xmitEmpty, xmitFull, level, overflow, thresh_irq
    );

    modport master (
        output busy, write_enable, pDataWrite, flush, overflow_clr,
        input  data_in, tx_enable, xmitEmpty, xmitFull, level, overflow, thresh_irq
    );
endinterface

// File: rtl/xmit_fifo_ctrl.sv
// xmit_fifo_ctrl: circular transmit buffer feeding a UART one word at a time.
// Define XMIT_FIFO_THRESH_EN to generate the registered low-watermark request.
module xmit_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 4
) (
    input logic       clk,
    input logic       n_rst,
    xmit_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nxt;
    logic [1:0]        state, state_nxt;
    logic [DATA_W-1:0] hold;
    logic              ovf, push, pop, drop, full, empty;
    logic              unused;

    assign unused = &{1'b0, bus.pDataWrite[31:DATA_W]};
    assign empty  = count == '0;
    assign full   = count == (AW+1)'(DEPTH);

    // full is judged before the pop, yet a pop in the same cycle frees a slot for the push
    always_comb begin
        pop       = state == POP && !bus.flush;
        push      = bus.write_enable && !bus.flush && (!full || pop);
        drop      = bus.write_enable && !bus.flush && full && !pop;
        count_nxt = bus.flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        state_nxt = bus.flush      ? IDLE :
                    state == IDLE  ? ((!bus.busy && !empty) ? POP : IDLE) :
                    state == POP   ? SEND :
                    state == SEND  ? GAP : IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
            hold   <= '1;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= bus.flush ? '0 : wr_ptr + AW'(push);
            rd_ptr <= bus.flush ? '0 : rd_ptr + AW'(pop);
            count  <= count_nxt;
            state  <= state_nxt;
            if (pop) hold <= mem[rd_ptr];
            ovf    <= drop | (ovf & !bus.overflow_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.pDataWrite[DATA_W-1:0];
    end

`ifdef XMIT_FIFO_THRESH_EN
    logic thr;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) thr <= 1'b0;
        else        thr <= !bus.flush && count_nxt <= (AW+1)'(THRESH);
    end
    assign bus.thresh_irq = thr;
`else
    logic unused_thresh;
    assign unused_thresh  = THRESH > 0;
    assign bus.thresh_irq = 1'b0;
`endif

    assign bus.tx_enable = state == SEND;
    assign bus.data_in   = state == SEND ? hold : '1;
    assign bus.xmitEmpty = empty;
    assign bus.xmitFull  = full;
    assign bus.level     = count;
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_xmit_fifo_ctrl.sv
// tb_xmit_fifo_ctrl: directed stimulus with a queue scoreboard of words expected at the transmitter.
module tb_xmit_fifo_ctrl;
    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int TH  = 4;

    logic clk = 1'b0;
    logic n_rst;
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];

    xmit_fifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();
    xmit_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEP), .THRESH(TH)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] v, input bit keep);
        bus.write_enable = 1'b1;
        bus.pDataWrite   = {24'h0, v};
        if (keep) exp_q.push_back(v);
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.xmitEmpty) && n < 400) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_empty"}, bus.xmitEmpty, 1);
    endtask

    // monitor: every transmitter load must match the oldest expected word
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.tx_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx: got %0h expected no load at %0t", bus.data_in, $time);
                end else chk("tx_data", bus.data_in, exp_q.pop_front());
            end else chk("idle_data", bus.data_in, 8'hFF);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        bus.busy = 1'b0;
        bus.write_enable = 1'b0;
        bus.pDataWrite = 32'h0;
        bus.flush = 1'b0;
        bus.overflow_clr = 1'b0;
        repeat (2) tick();
        chk("rst_data", bus.data_in, 8'hFF);
        chk("rst_tx", bus.tx_enable, 0);
        chk("rst_empty", bus.xmitEmpty, 1);
        chk("rst_full", bus.xmitFull, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_thr", bus.thresh_irq, 0);
        n_rst = 1'b1;
        tick();
        // single word latency
        wr(8'hA5, 1);
        chk("t1_level_a", bus.level, 1);
        chk("t1_tx_a", bus.tx_enable, 0);
        tick();
        chk("t1_tx_b", bus.tx_enable, 0);
        chk("t1_level_b", bus.level, 1);
        tick();
        chk("t1_tx_c", bus.tx_enable, 1);
        chk("t1_data", bus.data_in, 8'hA5);
        chk("t1_level_c", bus.level, 0);
        tick();
        chk("t1_tx_d", bus.tx_enable, 0);
        chk("t1_data_d", bus.data_in, 8'hFF);
        // fill, overflow, ordered drain
        bus.busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(i), 1);
        chk("t2_full", bus.xmitFull, 1);
        chk("t2_level", bus.level, 16);
        chk("t2_ovf0", bus.overflow, 0);
        wr(8'h55, 0);
        chk("t2_ovf1", bus.overflow, 1);
        chk("t2_level_ovf", bus.level, 16);
        bus.overflow_clr = 1'b1;
        tick();
        bus.overflow_clr = 1'b0;
        chk("t2_ovf_clr", bus.overflow, 0);
        bus.busy = 1'b0;
        drain("t2");
        // push into full FIFO during pop; pointers wrap
        bus.busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1);
        chk("t3_full", bus.xmitFull, 1);
        bus.busy = 1'b0;
        tick();
        bus.busy = 1'b1;
        wr(8'h3A, 1);
        chk("t3_level", bus.level, 16);
        chk("t3_ovf", bus.overflow, 0);
        chk("t3_full2", bus.xmitFull, 1);
        bus.busy = 1'b0;
        drain("t3");
        // flush discards contents and the concurrent write
        bus.busy = 1'b1;
        for (int i = 0; i < 3; i++) wr(8'h61 + 8'(i), 0);
        chk("t4_level_pre", bus.level, 3);
        bus.flush = 1'b1;
        wr(8'h77, 0);
        bus.flush = 1'b0;
        chk("t4_level", bus.level, 0);
        chk("t4_empty", bus.xmitEmpty, 1);
        chk("t4_ovf", bus.overflow, 0);
        bus.busy = 1'b0;
        repeat (12) tick();
        chk("t4_level_post", bus.level, 0);
        // reset while in SEND
        wr(8'h99, 1);
        tick();
        tick();
        chk("t5_tx", bus.tx_enable, 1);
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("t5_tx_rst", bus.tx_enable, 0);
        chk("t5_data_rst", bus.data_in, 8'hFF);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();
        chk("t5_level", bus.level, 0);
        chk("t5_empty", bus.xmitEmpty, 1);
        repeat (6) tick();
        chk("t5_tx_after", bus.tx_enable, 0);
        // low watermark
        bus.busy = 1'b1;
        for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i), 1);
        chk("t6_level", bus.level, 6);
        chk("t6_thr_hi", bus.thresh_irq, 0);
        bus.busy = 1'b0;
        for (int n = 0; n < 60 && (exp_q.size() != 0 || !bus.xmitEmpty); n++) begin
            tick();
`ifdef XMIT_FIFO_THRESH_EN
            chk("t6_thr", bus.thresh_irq, 32'(bus.level <= 5'(TH)));
`else
            chk("t6_thr", bus.thresh_irq, 0);
`endif
        end
        repeat (3) tick();
        chk("t6_left", exp_q.size(), 0);
`ifdef XMIT_FIFO_THRESH_EN
        chk("t6_thr_end", bus.thresh_irq, 1);
`else
        chk("t6_thr_end", bus.thresh_irq, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
